pipe_latch: RTL



---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_latch_if.sv | 27 ++
 rtl/wide_register.sv | 20 ++
 rtl/pipe_latch.sv | 138 +++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline-stage latch.
// Holds the occupancy state enum, the default bubble word and a field-offset helper.
package pipe_pkg;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    // Low bit index of field k in a packed multi-field word.
    function automatic int field_lo(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/pipe_latch_if.sv
// Handshake bundle between a pipeline stage latch and its neighbours.
// slave: latch side (consumes in_*, flush, out_ready); master: driving side.
interface pipe_latch_if #(
    parameter int WIDTH  = 32,
    parameter int FIELDS = 4,
    parameter int CNT_W  = 16
);
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [FIELDS*WIDTH-1:0]   in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [FIELDS*WIDTH-1:0]   out_data;
    logic [1:0]                occupancy;
    logic [CNT_W-1:0]          stall_count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy, stall_count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy, stall_count
    );
endinterface

// File: rtl/wide_register.sv
// Parametrised register with load enable and synchronous active-high reset.
// Ports: clk_i, rst_i (sync reset to RST_VAL), en_i (load), d_i, q_o.
module wide_register #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= RST_VAL;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end
endmodule

// File: rtl/pipe_latch.sv
// Pipeline stage latch: two-entry skid buffer, flush, registered NOP bubble, stall counter.
// Ports: clock, ctrl_reset (sync, active-high), bus (pipe_latch_if.slave).
module pipe_latch
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               FIELDS    = 4,
    parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(NOP_DEFAULT),
    parameter int               CNT_W     = 16
) (
    input  logic       clock,
    input  logic       ctrl_reset,
    pipe_latch_if.slave bus
);
    localparam int            DW      = FIELDS * WIDTH;
    localparam logic [DW-1:0] NOP_VEC = {FIELDS{NOP_VALUE}};

    logic             main_v_q;
    logic             skid_v_q;
    state_t           cur_state;
    state_t           state_d;
    logic             main_en;
    logic             skid_en;
    logic [DW-1:0]    main_d;
    logic [DW-1:0]    main_q;
    logic [DW-1:0]    skid_q;
    logic             in_xfer;
    logic             out_xfer;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] stall_d;

    wide_register #(.W(DW), .RST_VAL(NOP_VEC)) u_main (
        .clk_i(clock),
        .rst_i(ctrl_reset),
        .en_i (main_en),
        .d_i  (main_d),
        .q_o  (main_q)
    );

    wide_register #(.W(DW), .RST_VAL(NOP_VEC)) u_skid (
        .clk_i(clock),
        .rst_i(ctrl_reset),
        .en_i (skid_en),
        .d_i  (bus.in_data),
        .q_o  (skid_q)
    );

    // in_ready comes straight from the skid valid flop.
    assign in_xfer  = bus.in_valid & ~skid_v_q;
    assign out_xfer = main_v_q & bus.out_ready;

    always_comb begin
        if (skid_v_q) begin
            cur_state = TWO;
        end else if (main_v_q) begin
            cur_state = ONE;
        end else begin
            cur_state = EMPTY;
        end
    end

    // State register: valid bits are the stored state.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            main_v_q <= (state_d != EMPTY);
            skid_v_q <= (state_d == TWO);
        end
    end

    // Next state and entry loads.
    always_comb begin
        state_d = cur_state;
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = bus.in_data;
        case (cur_state)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = ONE;
                    main_en = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_en = 1'b1;
                end else if (in_xfer) begin
                    state_d = TWO;
                    skid_en = 1'b1;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                    main_en = 1'b1;
                    main_d  = NOP_VEC;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    state_d = ONE;
                    main_en = 1'b1;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Main is reloaded with the bubble so out_data stays registered.
        if (bus.flush) begin
            state_d = EMPTY;
            main_en = 1'b1;
            main_d  = NOP_VEC;
            skid_en = 1'b0;
        end
    end

    // Outputs.
    assign bus.in_ready    = ~skid_v_q;
    assign bus.out_valid   = main_v_q;
    assign bus.out_data    = main_q;
    assign bus.occupancy   = cur_state;
    assign bus.stall_count = stall_q;

    // Saturating stall counter; only reset clears it.
    always_comb begin
        stall_d = stall_q;
        if (main_v_q && !bus.out_ready && stall_q != {CNT_W{1'b1}}) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
endmodule
